// File: rtl/soma_spike_generator.sv
// Somatic leaky integrate-and-fire stage of the two-compartment pyramidal cell.
// Integrates dendritic drive in Q14 on each clk_en tick. A threshold crossing
// emits a single spike followed by a refractory period. If the crossing
// coincides with BAC firing, the stage instead emits a committed burst and
// then enters the refractory period.
module soma_spike_generator #(
  parameter int WIDTH        = 18,
  parameter int FRAC         = 14,
  parameter int LEAK_SHIFT   = 3,
  parameter int V_THRESH     = 8192,
  parameter int V_RESET      = 0,
  parameter int REFRAC_TICKS = 8,
  parameter int BURST_LEN    = 3,
  parameter int BURST_ISI    = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clk_en,
  input  logic signed [WIDTH-1:0] dendritic_input,
  input  logic                    bac_active,
  output logic signed [WIDTH-1:0] v_mem,
  output logic                    spike,
  output logic                    burst_active,
  output logic                    refractory,
  output logic [15:0]             spike_count
);

  if (FRAC >= WIDTH || BURST_LEN < 2 || BURST_LEN > 15 ||
      BURST_ISI < 1 || BURST_ISI > 15) begin : g_param_check
    $error("soma_spike_generator: parameter out of range");
  end

  localparam int DW = WIDTH + 1;
  localparam int SW = WIDTH + 2;
  localparam int RW = (REFRAC_TICKS < 2) ? 1 : $clog2(REFRAC_TICKS + 1);

  localparam logic signed [WIDTH-1:0] VTH  = WIDTH'(V_THRESH);
  localparam logic signed [WIDTH-1:0] VRST = WIDTH'(V_RESET);
  // Symmetric saturation range: the most negative code is never produced.
  localparam logic signed [SW-1:0]    VMAX = {3'b000, {(WIDTH-1){1'b1}}};
  localparam logic signed [SW-1:0]    VMIN = -VMAX;

  typedef enum logic [1:0] {
    INTEG  = 2'd0,
    BURST  = 2'd1,
    REFRAC = 2'd2
  } state_t;

  // With no refractory period, the tick after a spike is already integration.
  localparam state_t AFTER_SPIKE = (REFRAC_TICKS == 0) ? INTEG : REFRAC;

  state_t                  state, state_n;
  logic signed [WIDTH-1:0] v_q, v_n, v_next;
  logic [3:0]              burst_left, burst_n;
  logic [3:0]              isi_cnt, isi_n;
  logic [RW-1:0]           ref_cnt, ref_n;
  logic                    fire;

  logic signed [DW-1:0]    diff, step;
  logic signed [SW-1:0]    sum;

  // Leaky integration step: v + ((in - v) >>> LEAK_SHIFT), saturated.
  always_comb begin
    diff = $signed({dendritic_input[WIDTH-1], dendritic_input}) -
           $signed({v_q[WIDTH-1], v_q});
    step = diff >>> LEAK_SHIFT;
    sum  = $signed({{2{v_q[WIDTH-1]}}, v_q}) + $signed({step[DW-1], step});
    if (sum > VMAX) begin
      v_next = VMAX[WIDTH-1:0];
    end else if (sum < VMIN) begin
      v_next = VMIN[WIDTH-1:0];
    end else begin
      v_next = sum[WIDTH-1:0];
    end
  end

  // Next-state logic. Only clk_en ticks advance the machine.
  always_comb begin
    state_n = state;
    v_n     = v_q;
    burst_n = burst_left;
    isi_n   = isi_cnt;
    ref_n   = ref_cnt;
    fire    = 1'b0;
    if (clk_en) begin
      case (state)
        INTEG: begin
          if (v_next >= VTH) begin
            fire = 1'b1;
            v_n  = VRST;
            if (bac_active) begin
              state_n = BURST;
              burst_n = 4'(BURST_LEN - 1);
              isi_n   = 4'(BURST_ISI);
            end else begin
              state_n = AFTER_SPIKE;
              ref_n   = RW'(REFRAC_TICKS);
            end
          end else begin
            v_n = v_next;
          end
        end
        BURST: begin
          // Committed: bac_active is not consulted once the burst starts.
          v_n = VRST;
          if (isi_cnt <= 4'd1) begin
            fire  = 1'b1;
            isi_n = 4'(BURST_ISI);
            if (burst_left <= 4'd1) begin
              burst_n = '0;
              state_n = AFTER_SPIKE;
              ref_n   = RW'(REFRAC_TICKS);
            end else begin
              burst_n = burst_left - 4'd1;
            end
          end else begin
            isi_n = isi_cnt - 4'd1;
          end
        end
        REFRAC: begin
          v_n = VRST;
          if (ref_cnt <= RW'(1)) begin
            ref_n   = '0;
            state_n = INTEG;
          end else begin
            ref_n = ref_cnt - RW'(1);
          end
        end
        default: begin
          state_n = INTEG;
          v_n     = VRST;
        end
      endcase
    end
  end

  // State, counters and registered outputs; spike self-clears on the next edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= INTEG;
      v_q         <= '0;
      burst_left  <= '0;
      isi_cnt     <= '0;
      ref_cnt     <= '0;
      spike       <= 1'b0;
      spike_count <= '0;
    end else begin
      state      <= state_n;
      v_q        <= v_n;
      burst_left <= burst_n;
      isi_cnt    <= isi_n;
      ref_cnt    <= ref_n;
      spike      <= fire;
      if (fire && spike_count != '1) begin
        spike_count <= spike_count + 16'd1;
      end
    end
  end

  assign v_mem        = v_q;
  assign burst_active = (state == BURST);
  assign refractory   = (state == REFRAC);

endmodule

// File: tb/tb_soma_spike_generator.sv
// Directed self-checking bench for soma_spike_generator. The main instance
// uses default parameters; a second instance with no refractory period is
// used to reach the spike counter saturation point in a short run.
module tb_soma_spike_generator;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic clk_en = 1'b0;
  logic signed [17:0] din = '0;
  logic bac = 1'b0;
  logic signed [17:0] v_mem;
  logic spike, burst_active, refractory;
  logic [15:0] spike_count;

  logic clk_en2 = 1'b0;
  logic signed [17:0] din2 = '0;
  logic bac2 = 1'b0;
  logic signed [17:0] v_mem2;
  logic spike2, burst_active2, refractory2;
  logic [15:0] spike_count2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  soma_spike_generator dut (
    .clk(clk), .rst(rst), .clk_en(clk_en),
    .dendritic_input(din), .bac_active(bac),
    .v_mem(v_mem), .spike(spike), .burst_active(burst_active),
    .refractory(refractory), .spike_count(spike_count)
  );

  soma_spike_generator #(.REFRAC_TICKS(0)) dut_sat (
    .clk(clk), .rst(rst), .clk_en(clk_en2),
    .dendritic_input(din2), .bac_active(bac2),
    .v_mem(v_mem2), .spike(spike2), .burst_active(burst_active2),
    .refractory(refractory2), .spike_count(spike_count2)
  );

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clk_en tick, then one idle edge on which spike must have cleared.
  task automatic tick(output logic sp);
    @(negedge clk);
    clk_en = 1'b1;
    @(posedge clk);
    #1;
    sp = spike;
    clk_en = 1'b0;
    @(posedge clk);
    #1;
    chk("spike_one_clk", spike, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic sp;
    logic saw;
    logic neg;
    logic [31:0] mask;
    int exp_v[5] = '{2048, 3840, 5408, 6780, 7980};

    // Reset values
    #12;
    chk("rst_v_mem", v_mem, 0);
    chk("rst_spike", spike, 0);
    chk("rst_burst", burst_active, 0);
    chk("rst_refrac", refractory, 0);
    chk("rst_count", spike_count, 0);
    @(negedge clk);
    rst = 1'b0;

    // Subthreshold drive settles just below the input, never spikes
    din = 18'sd8191;
    saw = 1'b0;
    repeat (200) begin
      tick(sp);
      if (sp) saw = 1'b1;
    end
    chk("sub_no_spike", saw, 0);
    chk("sub_settle", (v_mem >= 8184 && v_mem <= 8191), 1);
    chk("sub_count", spike_count, 0);

    // Single spike timing
    do_reset();
    din = 18'sd16384;
    for (int i = 0; i < 5; i++) begin
      tick(sp);
      chk("single_v_seq", v_mem, exp_v[i]);
      chk("single_no_early_spike", sp, 0);
    end
    tick(sp);
    chk("single_spike_t6", sp, 1);
    chk("single_v_reset", v_mem, 0);
    chk("single_refrac_t6", refractory, 1);
    saw = 1'b0;
    for (int t = 7; t <= 14; t++) begin
      tick(sp);
      if (sp) saw = 1'b1;
      if (t == 13) chk("single_refrac_t13", refractory, 1);
      if (t == 14) chk("single_refrac_end_t14", refractory, 0);
    end
    chk("single_no_spike_refrac", saw, 0);
    tick(sp);
    chk("single_resume_v_t15", v_mem, 2048);
    chk("single_resume_spike_t15", sp, 0);
    chk("single_count", spike_count, 1);

    // Burst with BAC held high
    do_reset();
    din = 18'sd16384;
    bac = 1'b1;
    mask = '0;
    for (int t = 1; t <= 20; t++) begin
      tick(sp);
      if (sp) mask[t] = 1'b1;
      if (t == 6) chk("burst_active_t6", burst_active, 1);
      if (t == 10) chk("burst_refrac_t10", refractory, 1);
      if (t == 10) chk("burst_done_t10", burst_active, 0);
      if (t == 17) chk("burst_refrac_t17", refractory, 1);
      if (t == 18) chk("burst_refrac_end_t18", refractory, 0);
    end
    chk("burst_spike_ticks", mask, 32'h0000_0540);
    chk("burst_count", spike_count, 3);

    // Committed burst: BAC drops after the first spike
    do_reset();
    din = 18'sd16384;
    bac = 1'b1;
    mask = '0;
    for (int t = 1; t <= 20; t++) begin
      tick(sp);
      if (sp) mask[t] = 1'b1;
      if (t == 6) bac = 1'b0;
    end
    chk("commit_spike_ticks", mask, 32'h0000_0540);
    chk("commit_count", spike_count, 3);

    // Asynchronous reset right after the first burst spike
    do_reset();
    din = 18'sd16384;
    bac = 1'b1;
    repeat (5) tick(sp);
    @(negedge clk);
    clk_en = 1'b1;
    @(posedge clk);
    #1;
    chk("areset_pre_spike", spike, 1);
    chk("areset_pre_burst", burst_active, 1);
    clk_en = 1'b0;
    #1;
    rst = 1'b1;
    #1;
    chk("areset_spike", spike, 0);
    chk("areset_burst", burst_active, 0);
    chk("areset_refrac", refractory, 0);
    chk("areset_v_mem", v_mem, 0);
    chk("areset_count", spike_count, 0);
    @(negedge clk);
    rst = 1'b0;
    din = '0;
    bac = 1'b0;
    saw = 1'b0;
    repeat (10) begin
      tick(sp);
      if (sp) saw = 1'b1;
    end
    chk("areset_no_more_spikes", saw, 0);
    chk("areset_integ_state", {burst_active, refractory}, 0);

    // Full-scale positive drive: spike every REFRAC_TICKS+1 ticks, v never negative
    do_reset();
    din = 18'sd131071;
    neg = 1'b0;
    repeat (30) begin
      tick(sp);
      if (v_mem < 0) neg = 1'b1;
    end
    chk("pos_sat_no_wrap", neg, 0);
    chk("pos_sat_count", spike_count, 4);

    // Full-scale negative drive saturates at -(2^17-1)
    do_reset();
    din = -18'sd131072;
    saw = 1'b0;
    repeat (200) begin
      tick(sp);
      if (sp) saw = 1'b1;
    end
    chk("neg_sat_v", v_mem, -131071);
    chk("neg_sat_no_spike", saw, 0);

    // Spike counter saturation on the zero-refractory instance
    do_reset();
    din = '0;
    @(negedge clk);
    din2 = 18'sd131071;
    clk_en2 = 1'b1;
    repeat (65534) @(posedge clk);
    #1;
    chk("cnt_pre_sat", spike_count2, 65534);
    chk("cnt_spike_high", spike2, 1);
    chk("zero_refrac_never_refractory", refractory2, 0);
    @(posedge clk);
    #1;
    chk("cnt_at_sat", spike_count2, 65535);
    repeat (5) @(posedge clk);
    #1;
    chk("cnt_hold_sat", spike_count2, 65535);
    chk("cnt_v_nonneg", (v_mem2 >= 0), 1);
    @(negedge clk);
    clk_en2 = 1'b0;
    @(posedge clk);
    #1;
    chk("sat_spike_clear", spike2, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
